// File: rtl/elevator_request_queue_pkg.sv
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared floor constants and width helpers for the elevator
//                request queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam logic [1:0] LVL_A = 2'd0;
    localparam logic [1:0] LVL_B = 2'd1;
    localparam logic [1:0] LVL_C = 2'd2;
    localparam logic [1:0] LVL_D = 2'd3;

    localparam int DROP_CNT_W = 16;

    // A single-floor build still needs a 1-bit level field.
    function automatic int lvl_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_request_queue_if.sv
// ============================================================================
//  Module      : elevator_request_queue_if
//  Description : Press/arrival inputs and queue status outputs of the
//                request queue. Carries drop_cnt when
//                ELEVATOR_QUEUE_DROP_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elevator_request_queue_if
    import elevator_pkg::*;
#(
    parameter int NUM_LVLS = 4,
    parameter int DEPTH    = 4
);
    localparam int LVL_W = lvl_w(NUM_LVLS);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                   press_valid;
    logic [LVL_W-1:0]       press_lvl;
    logic                   arrive_valid;
    logic [LVL_W-1:0]       arrive_lvl;
    logic                   press_accept;
    logic                   head_valid;
    logic [LVL_W-1:0]       head_lvl;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic [DEPTH*LVL_W-1:0] queue_flat;
`ifdef ELEVATOR_QUEUE_DROP_CNT_EN
    logic [DROP_CNT_W-1:0]  drop_cnt;

    modport master (
        output press_valid, press_lvl, arrive_valid, arrive_lvl,
        input  press_accept, head_valid, head_lvl, count, full, queue_flat, drop_cnt
    );
    modport slave (
        input  press_valid, press_lvl, arrive_valid, arrive_lvl,
        output press_accept, head_valid, head_lvl, count, full, queue_flat, drop_cnt
    );
`else
    modport master (
        output press_valid, press_lvl, arrive_valid, arrive_lvl,
        input  press_accept, head_valid, head_lvl, count, full, queue_flat
    );
    modport slave (
        input  press_valid, press_lvl, arrive_valid, arrive_lvl,
        output press_accept, head_valid, head_lvl, count, full, queue_flat
    );
`endif

endinterface

`default_nettype wire

// File: rtl/elevator_request_queue_match.sv
// ============================================================================
//  Module      : lvl_in_queue_match
//  Description : Finds which occupied queue slot holds a given level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvl_in_queue_match
    import elevator_pkg::*;
#(
    parameter  int NUM_LVLS = 4,
    parameter  int DEPTH    = 4,
    localparam int LVL_W    = lvl_w(NUM_LVLS),
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  wire logic [LVL_W-1:0]       i_lvl,
    input  wire logic [DEPTH*LVL_W-1:0] i_queue_flat,
    input  wire logic [CNT_W-1:0]       i_count,
    output logic                        o_hit,
    output logic [DEPTH-1:0]            o_hit_idx
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign o_hit_idx[i] = (CNT_W'(i) < i_count) &&
                              (i_queue_flat[i*LVL_W +: LVL_W] == i_lvl);
    end

    assign o_hit = |o_hit_idx;

endmodule

`default_nettype wire

// File: rtl/elevator_request_queue.sv
// ============================================================================
//  Module      : elevator_request_queue
//  Description : Arrival-ordered floor request queue with duplicate rejection
//                and compaction on arrival. Define ELEVATOR_QUEUE_DROP_CNT_EN
//                for a saturating rejected-press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_request_queue
    import elevator_pkg::*;
#(
    parameter int NUM_LVLS = 4,
    parameter int DEPTH    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    elevator_request_queue_if.slave bus
);

    localparam int LVL_W = lvl_w(NUM_LVLS);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [LVL_W-1:0]       r_slot [DEPTH];
    logic [CNT_W-1:0]       r_count;
    logic                   r_full;
    logic                   r_head_valid;

    logic [LVL_W-1:0]       w_slot_nxt [DEPTH];
    logic [DEPTH*LVL_W-1:0] w_flat;
    logic                   w_press_hit_raw;
    logic [DEPTH-1:0]       w_press_idx;
    logic                   w_press_hit;
    logic                   w_arr_hit;
    logic [DEPTH-1:0]       w_arr_idx;
    logic                   w_rm;
    logic [DEPTH-1:0]       w_rm_idx;
    logic [DEPTH-1:0]       w_shift;
    logic                   w_lvl_ok;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_wr_idx;
    logic [CNT_W-1:0]       w_count_nxt;

    lvl_in_queue_match #(.NUM_LVLS(NUM_LVLS), .DEPTH(DEPTH)) u_press_match (
        .i_lvl        (bus.press_lvl),
        .i_queue_flat (w_flat),
        .i_count      (r_count),
        .o_hit        (w_press_hit_raw),
        .o_hit_idx    (w_press_idx)
    );

    lvl_in_queue_match #(.NUM_LVLS(NUM_LVLS), .DEPTH(DEPTH)) u_arr_match (
        .i_lvl        (bus.arrive_lvl),
        .i_queue_flat (w_flat),
        .i_count      (r_count),
        .o_hit        (w_arr_hit),
        .o_hit_idx    (w_arr_idx)
    );

    assign w_press_hit = w_press_hit_raw | (|w_press_idx);
    assign w_rm        = bus.arrive_valid & w_arr_hit;
    assign w_rm_idx    = w_arr_idx & {DEPTH{bus.arrive_valid}};
    assign w_lvl_ok    = ({1'b0, bus.press_lvl} < (LVL_W+1)'(NUM_LVLS));

    // A press for the floor the car is stopping at is already satisfied.
    assign w_accept = bus.press_valid & ~w_press_hit & w_lvl_ok
                    & ~(bus.arrive_valid & (bus.press_lvl == bus.arrive_lvl))
                    & (~r_full | w_rm);

    assign w_wr_idx    = r_count - {{(CNT_W-1){1'b0}}, w_rm};
    assign w_count_nxt = w_wr_idx + {{(CNT_W-1){1'b0}}, w_accept};

    // Slots at and behind the removed entry pull from their successor; the
    // tail refills with zero because unused slots are held at zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [LVL_W-1:0] w_comp;

        assign w_flat[i*LVL_W +: LVL_W] = r_slot[i];
        assign w_shift[i]               = |w_rm_idx[i:0];

        if (i == DEPTH-1) begin : g_last
            assign w_comp = w_shift[i] ? '0 : r_slot[i];
        end else begin : g_mid
            assign w_comp = w_shift[i] ? r_slot[i+1] : r_slot[i];
        end

        assign w_slot_nxt[i] = (w_accept && (w_wr_idx == CNT_W'(i))) ? bus.press_lvl : w_comp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot       <= '{default: '0};
            r_count      <= '0;
            r_full       <= 1'b0;
            r_head_valid <= 1'b0;
        end else begin
            r_slot       <= w_slot_nxt;
            r_count      <= w_count_nxt;
            r_full       <= (w_count_nxt == CNT_W'(DEPTH));
            r_head_valid <= (w_count_nxt != '0);
        end
    end

    assign bus.press_accept = w_accept;
    assign bus.head_valid   = r_head_valid;
    assign bus.head_lvl     = r_slot[0];
    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.queue_flat   = w_flat;

`ifdef ELEVATOR_QUEUE_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (bus.press_valid && !w_accept && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_queue.sv
// ============================================================================
//  Module      : tb_elevator_request_queue
//  Description : Scoreboard bench for elevator_request_queue with a list-based
//                reference model; covers ELEVATOR_QUEUE_DROP_CNT_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_request_queue;
    import elevator_pkg::*;

    localparam int NUM_LVLS = 4;
    localparam int DEPTH    = 4;
    localparam int LVL_W    = 2;

    typedef struct {
        bit acc;
        int cnt;
        bit hv;
        int head;
        bit full;
        int flat;
        int drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elevator_request_queue_if #(.NUM_LVLS(NUM_LVLS), .DEPTH(DEPTH)) bus ();

    elevator_request_queue #(.NUM_LVLS(NUM_LVLS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sbq[$];
    int   model_q[$];
    int   model_drop = 0;
    int   errors     = 0;
    int   checks     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_flat();
        int f = 0;
        foreach (model_q[i]) f |= model_q[i] << (i * LVL_W);
        return f;
    endfunction

    // Reference: a list in arrival order; removal deletes, acceptance appends.
    task automatic drive(input bit pv, input int pl, input bit av, input int al);
        bit   hit_p = 1'b0;
        int   rm_idx = -1;
        bit   acc;
        exp_t e;
        @(negedge clk);
        #1;
        bus.press_valid  = pv;
        bus.press_lvl    = pl[LVL_W-1:0];
        bus.arrive_valid = av;
        bus.arrive_lvl   = al[LVL_W-1:0];
        foreach (model_q[i]) if (model_q[i] == pl) hit_p = 1'b1;
        if (av) foreach (model_q[i]) if (model_q[i] == al) rm_idx = i;
        acc = pv && !hit_p && !(av && pl == al)
              && (model_q.size() < DEPTH || rm_idx >= 0) && pl < NUM_LVLS;
        if (rm_idx >= 0) model_q.delete(rm_idx);
        if (acc) model_q.push_back(pl);
        if (pv && !acc && model_drop < 65535) model_drop++;
        e.acc  = acc;
        e.cnt  = model_q.size();
        e.hv   = model_q.size() != 0;
        e.head = (model_q.size() != 0) ? model_q[0] : 0;
        e.full = model_q.size() == DEPTH;
        e.flat = model_flat();
        e.drop = model_drop;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sbq.size());
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_head_valid"}, 32'(bus.head_valid), 0);
        check({tag, "_full"}, 32'(bus.full), 0);
        check({tag, "_flat"}, 32'(bus.queue_flat), 0);
`ifdef ELEVATOR_QUEUE_DROP_CNT_EN
        check({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 0);
`endif
    endtask

    // Monitor: accept is sampled mid-cycle, registered outputs after the edge.
    initial begin
        logic a_acc;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                a_acc = bus.press_accept;
                @(posedge clk);
                #1;
                e = sbq.pop_front();
                check("press_accept", 32'(a_acc), 32'(e.acc));
                check("count", 32'(bus.count), 32'(e.cnt));
                check("head_valid", 32'(bus.head_valid), 32'(e.hv));
                check("head_lvl", 32'(bus.head_lvl), 32'(e.head));
                check("full", 32'(bus.full), 32'(e.full));
                check("queue_flat", 32'(bus.queue_flat), 32'(e.flat));
`ifdef ELEVATOR_QUEUE_DROP_CNT_EN
                check("drop_cnt", 32'(bus.drop_cnt), 32'(e.drop));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus.press_valid  = 1'b0;
        bus.press_lvl    = '0;
        bus.arrive_valid = 1'b0;
        bus.arrive_lvl   = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        #1 rst = 1'b0;

        // Fill B,C,D,A then remove C from the middle, then a miss
        drive(1, LVL_B, 0, 0);
        drive(1, LVL_C, 0, 0);
        drive(1, LVL_D, 0, 0);
        drive(1, LVL_A, 0, 0);
        drive(0, 0, 1, LVL_C);
        drive(0, 0, 1, LVL_C);
        drive(0, 0, 0, 0);
        wait_drain();

        // Asynchronous reset with three entries held
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_cleared("async_reset");
        model_q.delete();
        model_drop = 0;
        @(negedge clk);
        rst = 1'b0;

        // Duplicate against live entries, stale slot 3 must not match A
        drive(1, LVL_A, 0, 0);
        drive(1, LVL_B, 0, 0);
        drive(1, LVL_C, 0, 0);
        drive(1, LVL_B, 0, 0);
        drive(1, LVL_D, 0, 0);
        // Full queue: arrival frees a slot while the press is a duplicate
        drive(1, LVL_B, 1, LVL_A);
        drive(1, LVL_A, 0, 0);
        drive(1, LVL_C, 1, LVL_B);
        drive(1, LVL_B, 0, 0);
        drive(1, LVL_B, 1, LVL_B);
        drive(1, LVL_B, 0, 0);
        drive(1, LVL_D, 1, LVL_D);
        drive(1, LVL_D, 0, 0);
        drive(1, LVL_A, 0, 0);

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, NUM_LVLS - 1),
                  $urandom_range(0, 9) < 4, $urandom_range(0, NUM_LVLS - 1));
        end
        drive(0, 0, 0, 0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
